iomem_button_irq: RTL and testbench



---
 rtl/iomem_button_irq.sv | 142 ++++++++++++++
 tb/tb_iomem_button_irq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_button_irq.sv
// Debounced input block on the picosoc iomem bus: sticky rise/fall pending bits and a level irq.
// Define BTN_PRESS_COUNT_EN to add four saturating rise counters at word offset 4.
module iomem_button_irq #(
  parameter int         NUM_INPUTS      = 4,
  parameter int         DEBOUNCE_CYCLES = 12000,
  parameter logic [7:0] ADDR_BASE       = 8'h07
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic [31:0]           iomem_rdata,
  input  logic [NUM_INPUTS-1:0] pins_in,
  output logic                  irq
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_INPUTS-1:0] r_sync1, r_sync2, r_deb;
  logic [CW-1:0]         r_cnt [NUM_INPUTS];
  logic [31:0]           r_pend, r_en, r_rdata;
  logic                  r_ready, r_irq;

  logic [NUM_INPUTS-1:0] w_tog, w_rise, w_fall;
  logic [31:0]           w_set, w_impl, w_state, w_raw, w_rd, w_bmask, w_clr;
  logic                  w_sel, w_wr;
  logic [2:0]            w_off;
  logic                  w_unused;

  // A channel toggles on the last of DEBOUNCE_CYCLES consecutive mismatched samples.
  always_comb begin
    w_tog   = '0;
    w_rise  = '0;
    w_fall  = '0;
    w_set   = '0;
    w_impl  = '0;
    w_state = '0;
    w_raw   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_tog[i]      = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
      w_rise[i]     = w_tog[i] & ~r_deb[i];
      w_fall[i]     = w_tog[i] & r_deb[i];
      w_set[i]      = w_rise[i];
      w_set[16+i]   = w_fall[i];
      w_impl[i]     = 1'b1;
      w_impl[16+i]  = 1'b1;
      w_state[i]    = r_deb[i];
      w_raw[i]      = r_sync2[i];
    end
  end

  assign w_sel    = iomem_valid && !r_ready && (iomem_addr[31:24] == ADDR_BASE);
  assign w_wr     = w_sel && (iomem_wstrb != 4'b0000);
  assign w_off    = iomem_addr[4:2];
  assign w_bmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign w_clr    = (w_wr && (w_off == 3'd1)) ? (iomem_wdata & w_bmask) : 32'h0;
  assign w_unused = ^{iomem_addr[23:5], iomem_addr[1:0]};

`ifdef BTN_PRESS_COUNT_EN
  localparam int NC = (NUM_INPUTS < 4) ? NUM_INPUTS : 4;
  logic [7:0]  r_press [4];
  logic [3:0]  w_rise4, w_pclr;
  logic [31:0] w_count;

  always_comb begin
    w_rise4 = '0;
    for (int i = 0; i < NC; i++) w_rise4[i] = w_rise[i];
  end

  assign w_pclr  = (w_wr && (w_off == 3'd4)) ? iomem_wstrb : 4'b0000;
  assign w_count = {r_press[3], r_press[2], r_press[1], r_press[0]};

  // A clear in the same cycle as a rise still counts that rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) r_press[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_rise4[i])
          r_press[i] <= w_pclr[i] ? 8'd1 : ((r_press[i] == 8'hFF) ? 8'hFF : r_press[i] + 8'd1);
        else if (w_pclr[i])
          r_press[i] <= '0;
      end
    end
  end
`endif

  always_comb begin
    w_rd = '0;
    case (w_off)
      3'd0: w_rd = w_state;
      3'd1: w_rd = r_pend;
      3'd2: w_rd = r_en;
      3'd3: w_rd = w_raw;
`ifdef BTN_PRESS_COUNT_EN
      3'd4: w_rd = w_count;
`endif
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= pins_in;
      r_sync2 <= r_sync1;
      r_deb   <= r_deb ^ w_tog;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if ((r_sync2[i] == r_deb[i]) || w_tog[i]) r_cnt[i] <= '0;
        else                                      r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  // Event set is OR'ed after the clear so a coincident event wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_pend  <= '0;
      r_en    <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ready <= w_sel;
      if (w_sel) r_rdata <= w_rd;
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_wr && (w_off == 3'd2)) r_en <= (r_en & ~w_bmask) | (iomem_wdata & w_bmask & w_impl);
      r_irq <= |(r_pend & r_en);
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_irq;
endmodule

// File: tb/tb_iomem_button_irq.sv
// Bench for iomem_button_irq: register table, directed corner sequences and a
// randomized run against a sample-history reference model.
module tb_iomem_button_irq;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [3:0]  pins_in;
  logic        irq;

  int checks = 0;
  int errors = 0;

  iomem_button_irq #(.NUM_INPUTS(4), .DEBOUNCE_CYCLES(DB), .ADDR_BASE(8'h07)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .pins_in(pins_in), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference state: a channel's level flips once its last DB synchronised samples all disagree with it.
  logic [3:0]    m_s1, m_s2, m_deb;
  logic [DB-1:0] m_hist [4];
  logic [31:0]   m_pend, m_en, m_rdata;
  logic          m_ready, m_irq;
  logic [7:0]    m_cnt [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_en = '0; m_rdata = '0;
    m_ready = 1'b0; m_irq = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_hist[c] = '0;
      m_cnt[c]  = '0;
    end
  endtask

  task automatic step();
    logic [3:0]    n_deb, rise, fall, pin_now;
    logic [DB-1:0] hist_n [4];
    logic          sel, wr;
    logic [2:0]    off;
    logic [31:0]   bm, rdv, clr, pend_n, en_n;
    logic [7:0]    cnt_n [4];
    pin_now = pins_in;
    n_deb   = m_deb;
    for (int c = 0; c < 4; c++) begin
      hist_n[c] = {m_hist[c][DB-2:0], m_s2[c]};
      if (hist_n[c] == (m_deb[c] ? {DB{1'b0}} : {DB{1'b1}})) n_deb[c] = ~m_deb[c];
    end
    rise = n_deb & ~m_deb;
    fall = m_deb & ~n_deb;
    sel  = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h07);
    wr   = sel && (iomem_wstrb != 4'b0);
    off  = iomem_addr[4:2];
    bm   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    case (off)
      3'd0: rdv = {28'b0, m_deb};
      3'd1: rdv = m_pend;
      3'd2: rdv = m_en;
      3'd3: rdv = {28'b0, m_s2};
`ifdef BTN_PRESS_COUNT_EN
      3'd4: rdv = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
`endif
      default: rdv = 32'h0;
    endcase
    clr    = (wr && off == 3'd1) ? (iomem_wdata & bm) : 32'h0;
    pend_n = (m_pend & ~clr) | {12'b0, fall, 12'b0, rise};
    en_n   = (wr && off == 3'd2) ? ((m_en & ~bm) | (iomem_wdata & bm & 32'h000F_000F)) : m_en;
    for (int c = 0; c < 4; c++) begin
      cnt_n[c] = m_cnt[c];
`ifdef BTN_PRESS_COUNT_EN
      if (rise[c])
        cnt_n[c] = (wr && off == 3'd4 && iomem_wstrb[c]) ? 8'd1 : ((m_cnt[c] == 8'hFF) ? 8'hFF : m_cnt[c] + 8'd1);
      else if (wr && off == 3'd4 && iomem_wstrb[c])
        cnt_n[c] = 8'd0;
`endif
    end
    @(posedge clk);
    #1;
    m_irq = |(m_pend & m_en);
    m_ready = sel;
    if (sel) m_rdata = rdv;
    m_pend = pend_n;
    m_en = en_n;
    m_deb = n_deb;
    m_s2 = m_s1;
    m_s1 = pin_now;
    for (int c = 0; c < 4; c++) begin
      m_hist[c] = hist_n[c];
      m_cnt[c]  = cnt_n[c];
    end
    check("model_ready", {31'b0, iomem_ready}, {31'b0, m_ready});
    check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    check("model_rdata", iomem_rdata, m_rdata);
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] v, output logic ok);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; ok = 1'b0;
    for (int n = 0; n < 4 && !ok; n++) begin
      step();
      if (iomem_ready) ok = 1'b1;
    end
    v = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
  endtask

  task automatic acc(input string name, input logic [2:0] off, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] v);
    logic ok;
    bus({8'h07, 19'h0, off, 2'b00}, s, d, v, ok);
    check({name, "_ack"}, {31'b0, ok}, 32'h1);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [13];
    logic [31:0] v, a;
    logic        ok;

    tbl[0]  = '{32'h0700_0008, 4'b0000, 32'h0,         32'h0};
    tbl[1]  = '{32'h0700_0008, 4'b0101, 32'hFFFF_FFFF, 32'h0};
    tbl[2]  = '{32'h0700_0008, 4'b0000, 32'h0,         32'h000F_000F};
    tbl[3]  = '{32'h0700_0008, 4'b0001, 32'h0,         32'h000F_000F};
    tbl[4]  = '{32'h07FF_FF0B, 4'b0000, 32'h0,         32'h000F_0000};
    tbl[5]  = '{32'h0700_0008, 4'b1111, 32'h0,         32'h000F_0000};
    tbl[6]  = '{32'h0700_0000, 4'b1111, 32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{32'h0700_0000, 4'b0000, 32'h0,         32'h0};
    tbl[8]  = '{32'h0700_000C, 4'b0000, 32'h0,         32'h0};
    tbl[9]  = '{32'h0700_0010, 4'b0000, 32'h0,         32'h0};
    tbl[10] = '{32'h0700_0018, 4'b1111, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{32'h0700_001C, 4'b0000, 32'h0,         32'h0};
    tbl[12] = '{32'h0700_0008, 4'b0000, 32'h0,         32'h0};

    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
    pins_in = 4'b0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, iomem_ready}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    acc("rst_state", 3'd0, 4'b0, 32'h0, v); check("rst_state", v, 32'h0);
    acc("rst_pend", 3'd1, 4'b0, 32'h0, v);  check("rst_pend", v, 32'h0);
    acc("rst_en", 3'd2, 4'b0, 32'h0, v);    check("rst_en", v, 32'h0);

    for (int i = 0; i < 13; i++) begin
      bus(tbl[i].addr, tbl[i].strb, tbl[i].wdata, v, ok);
      check($sformatf("tbl%0d_ack", i), {31'b0, ok}, 32'h1);
      check($sformatf("tbl%0d_rdata", i), v, tbl[i].exp);
    end

    // Debounced rise of channel 0: not yet visible after 5 edges, visible after 6.
    pins_in[0] = 1'b1;
    steps(5);
    acc("deb5", 3'd0, 4'b0, 32'h0, v); check("deb_state_at5", v, 32'h0);
    acc("deb", 3'd0, 4'b0, 32'h0, v);  check("deb_state", v, 32'h1);
    acc("deb", 3'd1, 4'b0, 32'h0, v);  check("deb_pend", v, 32'h1);

    pins_in[1] = 1'b1; steps(3); pins_in[1] = 1'b0; steps(8);
    acc("glitch", 3'd0, 4'b0, 32'h0, v); check("glitch_state", v, 32'h1);
    acc("glitch", 3'd1, 4'b0, 32'h0, v); check("glitch_pend", v, 32'h1);

    acc("en", 3'd2, 4'b1111, 32'h0001_0000, v);
    pins_in[0] = 1'b0; steps(8);
    acc("irq", 3'd1, 4'b0, 32'h0, v); check("irq_pend", v, 32'h0001_0001);
    check("irq_high", {31'b0, irq}, 32'h1);
    acc("w1c", 3'd1, 4'b0100, 32'h0001_0000, v);
    step();
    check("irq_low", {31'b0, irq}, 32'h0);
    acc("w1c", 3'd1, 4'b0, 32'h0, v); check("w1c_pend", v, 32'h0000_0001);

    pins_in[3] = 1'b1; steps(6);
    acc("lat6", 3'd0, 4'b0, 32'h0, v); check("lat6_state", v, 32'h8);

    pins_in[2] = 1'b1; steps(5);
    acc("coll", 3'd1, 4'b0001, 32'h0000_0004, v); check("coll_pre", v, 32'h0000_0009);
    acc("coll", 3'd1, 4'b0, 32'h0, v); check("coll_pend", v, 32'h0000_000D);

    bus(32'h0600_0000, 4'b0, 32'h0, v, ok);
    check("nodecode_ack", {31'b0, ok}, 32'h0);
    bus(32'h0700_0014, 4'b0, 32'h0, v, ok);
    check("off5_ack", {31'b0, ok}, 32'h1);
    check("off5_rdata", v, 32'h0);
    step();
    check("ready_pulse", {31'b0, iomem_ready}, 32'h0);

`ifdef BTN_PRESS_COUNT_EN
    pins_in = 4'b0000; steps(8);
    acc("cnt_clr", 3'd4, 4'b1111, 32'h0, v);
    pins_in[1] = 1'b1; steps(5);
    acc("cnt_coll", 3'd4, 4'b0010, 32'h0, v);
    acc("cnt_coll", 3'd4, 4'b0, 32'h0, v); check("cnt_coll", v, 32'h0000_0100);
    pins_in[1] = 1'b0; steps(6);
    for (int p = 0; p < 300; p++) begin
      pins_in[1] = 1'b1; steps(6);
      pins_in[1] = 1'b0; steps(6);
    end
    acc("cnt_sat", 3'd4, 4'b0, 32'h0, v); check("cnt_sat", v, 32'h0000_FF00);
    acc("cnt_wr", 3'd4, 4'b0010, 32'h1234_5678, v);
    acc("cnt_wr", 3'd4, 4'b0, 32'h0, v); check("cnt_cleared", v, 32'h0);
`else
    acc("off4_wr", 3'd4, 4'b1111, 32'hFFFF_FFFF, v);
    acc("off4", 3'd4, 4'b0, 32'h0, v); check("off4_zero", v, 32'h0);
`endif

    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 11) == 0) pins_in = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = {(($urandom_range(0, 5) == 0) ? 8'h06 : 8'h07), 19'($urandom),
             3'($urandom_range(0, 7)), 2'($urandom)};
        bus(a, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0, $urandom, v, ok);
        check("rnd_ack", {31'b0, ok}, {31'b0, (a[31:24] == 8'h07)});
      end else begin
        step();
      end
    end
    for (int o = 0; o < 8; o++) acc("rnd_final", 3'(o), 4'b0, 32'h0, v);

    // Reset asserted in the middle of a pending access.
    pins_in = 4'b0101; steps(8);
    acc("pre_rst_en", 3'd2, 4'b1111, 32'h000F_000F, v);
    steps(2);
    iomem_valid = 1'b1; iomem_addr = 32'h0700_0004; iomem_wstrb = 4'b0;
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, iomem_ready}, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    check("mid_rst_rdata", iomem_rdata, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check("mid_rst_drop", {31'b0, iomem_ready}, 32'h0);
    iomem_valid = 1'b0;
    resetn = 1'b1;
    acc("post_rst", 3'd1, 4'b0, 32'h0, v); check("post_rst_pend", v, 32'h0);
    steps(8);
    acc("held_rise", 3'd1, 4'b0, 32'h0, v); check("held_rise_pend", v, 32'h0000_0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
